axis_fifo_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that shares one synchronous AXI-Stream FIFO between N_SOURCES requesters.
- Grants a whole frame (tvalid … tlast) to one source at a time.
- Admits a frame only when the FIFO reports enough free space for a maximum-size frame.
- Truncates and flags frames that exceed that size, so the FIFO never deadlocks mid-frame.
- Sits directly upstream of the FIFO wrapper; its output feeds the FIFO sink, and its fifo_depth input comes from the FIFO status depth.

---
 rtl/axis_fifo_arbiter_pkg.sv | 14 +
 rtl/axis_fifo_arbiter_picker.sv | 31 +++
 rtl/axis_fifo_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_fifo_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_arbiter_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream FIFO arbiter.
// The arbiter's sub-blocks import this package.
package axis_arb_pkg;

   typedef enum logic [1:0] {IDLE, PASS, DROP} arb_state_t;

   localparam int BAD_FRAME_BIT = 0;

   // Highest FIFO occupancy that still leaves room for one maximum-size frame.
   function automatic int space_threshold(input int fifo_capacity, input int max_frame_beats);
      return fifo_capacity - max_frame_beats;
   endfunction

endpackage

// File: rtl/axis_fifo_arbiter_picker.sv
// Combinational round-robin picker: the first requester after last_grant wins.
// The search wraps modulo N.
module rr_priority_picker #(
   parameter int N        = 4,
   parameter int ID_WIDTH = $clog2(N)
) (
   input  logic [N-1:0]        req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [ID_WIDTH-1:0] winner,
   output logic                any_req
);

   logic [ID_WIDTH-1:0] idx;
   logic                found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ID_WIDTH'((int'(last_grant) + i) % N);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Frame-granular round-robin arbiter feeding one shared AXI-Stream FIFO.
// Frames are admitted only when a full-size frame fits; overlong frames are cut and flagged.
module axis_fifo_arbiter #(
   parameter int N_SOURCES       = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int USER_WIDTH      = 1,
   parameter int FIFO_DEPTH      = 256,
   parameter int MAX_FRAME_BEATS = 64,
   parameter int ID_WIDTH        = $clog2(N_SOURCES)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [N_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [N_SOURCES-1:0]            s_axis_tvalid,
   output logic [N_SOURCES-1:0]            s_axis_tready,
   input  logic [N_SOURCES-1:0]            s_axis_tlast,
   input  logic [N_SOURCES*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [USER_WIDTH-1:0]           m_axis_tuser,
   output logic [ID_WIDTH-1:0]             m_axis_tid,
   input  logic [$clog2(FIFO_DEPTH):0]     fifo_depth,
   output logic                            grant_valid,
   output logic [ID_WIDTH-1:0]             grant_index,
   output logic [15:0]                     truncated_count
);

   import axis_arb_pkg::*;

   localparam int FD_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BC_W = $clog2(MAX_FRAME_BEATS) + 1;
   localparam logic [FD_W-1:0] ADMIT_LIMIT = FD_W'(space_threshold(FIFO_DEPTH, MAX_FRAME_BEATS));
   localparam logic [BC_W-1:0] LAST_BEAT   = BC_W'(MAX_FRAME_BEATS - 1);

   arb_state_t          state, next_state;
   logic [ID_WIDTH-1:0] last_grant;
   logic [ID_WIDTH-1:0] rr_winner;
   logic                any_req;
   logic                admit;
   logic [BC_W-1:0]     beat_cnt;

   logic [DATA_WIDTH-1:0] data_arr [N_SOURCES];
   logic [USER_WIDTH-1:0] user_arr [N_SOURCES];
   logic [DATA_WIDTH-1:0] src_data;
   logic [USER_WIDTH-1:0] src_user;
   logic                  src_valid;
   logic                  src_last;

   for (genvar i = 0; i < N_SOURCES; i++) begin : g_unpack
      assign data_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign user_arr[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
   end

   assign src_data  = data_arr[grant_index];
   assign src_user  = user_arr[grant_index];
   assign src_valid = s_axis_tvalid[grant_index];
   assign src_last  = s_axis_tlast[grant_index];

   rr_priority_picker #(
      .N        (N_SOURCES),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req        (s_axis_tvalid),
      .last_grant (last_grant),
      .winner     (rr_winner),
      .any_req    (any_req)
   );

   assign admit       = any_req && (fifo_depth <= ADMIT_LIMIT);
   assign grant_valid = (state != IDLE);
   assign m_axis_tid  = grant_index;

   // The cut beat is marked whenever it is presented, not only when accepted,
   // so the sink sees stable tlast/tuser while it stalls.
   always_comb begin
      next_state    = state;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = '0;
      case (state)
         IDLE: begin
            if (admit) next_state = PASS;
         end
         PASS: begin
            m_axis_tvalid              = src_valid;
            m_axis_tdata               = src_data;
            m_axis_tlast               = src_last;
            m_axis_tuser               = src_user;
            s_axis_tready[grant_index] = m_axis_tready;
            if (!src_last && beat_cnt == LAST_BEAT) begin
               m_axis_tlast                = 1'b1;
               m_axis_tuser[BAD_FRAME_BIT] = 1'b1;
            end
            if (src_valid && m_axis_tready) begin
               if (src_last)                    next_state = IDLE;
               else if (beat_cnt == LAST_BEAT) next_state = DROP;
            end
         end
         DROP: begin
            s_axis_tready[grant_index] = 1'b1;
            if (src_valid && src_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         last_grant      <= ID_WIDTH'(N_SOURCES - 1);
         beat_cnt        <= '0;
         truncated_count <= '0;
         grant_index     <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (admit) begin
                  grant_index <= rr_winner;
                  beat_cnt    <= '0;
               end
            end
            PASS: begin
               if (src_valid && m_axis_tready) begin
                  beat_cnt <= beat_cnt + BC_W'(1);
                  if (src_last)
                     last_grant <= grant_index;
                  else if (beat_cnt == LAST_BEAT && truncated_count != 16'hFFFF)
                     truncated_count <= truncated_count + 16'd1;
               end
            end
            DROP: begin
               if (src_valid && src_last) last_grant <= grant_index;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Directed testbench for axis_fifo_arbiter with hand-computed expectations.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
module tb_axis_fifo_arbiter;

   localparam int NS  = 4;
   localparam int DW  = 8;
   localparam int UW  = 1;
   localparam int FD  = 256;
   localparam int MFB = 64;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NS*DW-1:0]  s_axis_tdata;
   logic [NS-1:0]     s_axis_tvalid;
   logic [NS-1:0]     s_axis_tready;
   logic [NS-1:0]     s_axis_tlast;
   logic [NS*UW-1:0]  s_axis_tuser;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic [UW-1:0]     m_axis_tuser;
   logic [IW-1:0]     m_axis_tid;
   logic [8:0]        fifo_depth;
   logic              grant_valid;
   logic [IW-1:0]     grant_index;
   logic [15:0]       truncated_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_fifo_arbiter #(
      .N_SOURCES       (NS),
      .DATA_WIDTH      (DW),
      .USER_WIDTH      (UW),
      .FIFO_DEPTH      (FD),
      .MAX_FRAME_BEATS (MFB),
      .ID_WIDTH        (IW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tuser    (s_axis_tuser),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tid      (m_axis_tid),
      .fifo_depth      (fifo_depth),
      .grant_valid     (grant_valid),
      .grant_index     (grant_index),
      .truncated_count (truncated_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int src, input logic valid, input logic [7:0] data, input logic last);
      s_axis_tvalid[src]        = valid;
      s_axis_tdata[src*DW +: DW] = data;
      s_axis_tlast[src]         = last;
      s_axis_tuser[src]         = 1'b0;
   endtask

   task automatic idleAll();
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      s_axis_tuser  = '0;
   endtask

   // One frame of nbeats from src, with the sink always ready; it starts and ends in IDLE.
   task automatic runFrame(input int src, input int nbeats, input string tag);
      int   sent     = 0;
      logic accepted = 1'b0;
      for (int c = 0; c <= nbeats; c++) begin
         if (accepted) sent++;
         if (sent < nbeats) applyStimulus(src, 1'b1, 8'(sent), sent == nbeats - 1);
         else               applyStimulus(src, 1'b0, 8'h00, 1'b0);
         #1;
         if (c == 0) begin
            checkOutput({tag, "_idle_valid"}, m_axis_tvalid, 0);
            checkOutput({tag, "_idle_ready"}, s_axis_tready, 0);
         end else if (c <= MFB) begin
            checkOutput({tag, "_valid"}, m_axis_tvalid, 1);
            checkOutput({tag, "_tid"},   m_axis_tid, src);
            checkOutput({tag, "_data"},  m_axis_tdata, c - 1);
            checkOutput({tag, "_last"},  m_axis_tlast, (c == nbeats) || (c == MFB));
            checkOutput({tag, "_user"},  m_axis_tuser, (c == MFB) && (nbeats > MFB));
            checkOutput({tag, "_ready"}, s_axis_tready, 32'd1 << src);
         end else begin
            checkOutput({tag, "_drop_valid"}, m_axis_tvalid, 0);
            checkOutput({tag, "_drop_ready"}, s_axis_tready, 32'd1 << src);
         end
         accepted = s_axis_tready[src] && s_axis_tvalid[src];
         @(negedge clk);
      end
      applyStimulus(src, 1'b0, 8'h00, 1'b0);
      #1;
      checkOutput({tag, "_consumed"}, sent + int'(accepted), nbeats);
      checkOutput({tag, "_end_gv"}, grant_valid, 0);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] beat [NS];
      logic [NS-1:0] acc;
      logic [7:0] rx [8];
      int   nrx;
      int   sent;
      logic accepted;
      int   phase, tid, round;

      reset         = 1'b1;
      m_axis_tready = 1'b1;
      fifo_depth    = '0;
      idleAll();
      repeat (2) @(negedge clk);
      checkOutput("rst_gv",     grant_valid, 0);
      checkOutput("rst_gi",     grant_index, 0);
      checkOutput("rst_tc",     truncated_count, 0);
      checkOutput("rst_sready", s_axis_tready, 0);
      checkOutput("rst_mvalid", m_axis_tvalid, 0);
      reset = 1'b0;

      $display("[TB] single source frame");
      applyStimulus(0, 1'b1, 8'h11, 1'b0);
      #1 checkOutput("s1_latency", m_axis_tvalid, 0);
      @(negedge clk);
      checkOutput("s1_valid0", m_axis_tvalid, 1);
      checkOutput("s1_data0",  m_axis_tdata, 8'h11);
      checkOutput("s1_tid",    m_axis_tid, 0);
      checkOutput("s1_last0",  m_axis_tlast, 0);
      checkOutput("s1_ready",  s_axis_tready, 4'b0001);
      @(negedge clk);
      applyStimulus(0, 1'b1, 8'h22, 1'b0);
      #1 checkOutput("s1_data1", m_axis_tdata, 8'h22);
      @(negedge clk);
      applyStimulus(0, 1'b1, 8'h33, 1'b1);
      #1 checkOutput("s1_data2", m_axis_tdata, 8'h33);
      checkOutput("s1_last2", m_axis_tlast, 1);
      @(negedge clk);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      #1 checkOutput("s1_done_gv", grant_valid, 0);
      checkOutput("s1_hold_gi", grant_index, 0);

      $display("[TB] round-robin fairness");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NS; i++) beat[i] = '0;
      acc = '0;
      for (int k = 0; k < 15; k++) begin
         for (int i = 0; i < NS; i++) begin
            if (acc[i]) beat[i] = beat[i] + 4'd1;
            applyStimulus(i, 1'b1, {4'(i), beat[i]}, beat[i][0]);
         end
         #1;
         phase = k % 3;
         tid   = (k / 3) % 4;
         round = k / 12;
         checkOutput("fair_valid", m_axis_tvalid, phase != 0);
         if (phase != 0) begin
            checkOutput("fair_tid",  m_axis_tid, tid);
            checkOutput("fair_data", m_axis_tdata, {24'd0, 4'(tid), 4'(round * 2 + phase - 1)});
            checkOutput("fair_last", m_axis_tlast, phase == 2);
         end
         acc = s_axis_tready & s_axis_tvalid;
         @(negedge clk);
      end
      idleAll();

      $display("[TB] admission threshold");
      fifo_depth = 9'd193;
      applyStimulus(1, 1'b1, 8'h5A, 1'b1);
      repeat (3) begin
         #1;
         checkOutput("adm_block_ready", s_axis_tready, 0);
         checkOutput("adm_block_valid", m_axis_tvalid, 0);
         checkOutput("adm_block_gv",    grant_valid, 0);
         @(negedge clk);
      end
      fifo_depth = 9'd192;
      #1 checkOutput("adm_same_cycle_gv", grant_valid, 0);
      @(negedge clk);
      checkOutput("adm_gv",   grant_valid, 1);
      checkOutput("adm_gi",   grant_index, 1);
      checkOutput("adm_data", m_axis_tdata, 8'h5A);
      @(negedge clk);
      idleAll();
      fifo_depth = '0;
      #1 checkOutput("adm_done_gv", grant_valid, 0);
      @(negedge clk);

      $display("[TB] truncation");
      runFrame(2, 70, "trunc");
      checkOutput("trunc_count", truncated_count, 1);
      runFrame(3, 64, "full");
      checkOutput("full_count", truncated_count, 1);

      $display("[TB] backpressure");
      sent     = 0;
      accepted = 1'b0;
      nrx      = 0;
      for (int c = 0; c < 20; c++) begin
         if (accepted) sent++;
         if (sent < 6) applyStimulus(0, 1'b1, 8'hA0 + 8'(sent), sent == 5);
         else          applyStimulus(0, 1'b0, 8'h00, 1'b0);
         m_axis_tready = c[0];
         #1;
         if (m_axis_tvalid) begin
            checkOutput("bp_mirror", s_axis_tready, {3'b000, m_axis_tready});
            if (m_axis_tready && nrx < 8) begin
               rx[nrx] = m_axis_tdata;
               nrx++;
            end
         end
         accepted = s_axis_tready[0] && s_axis_tvalid[0];
         @(negedge clk);
      end
      m_axis_tready = 1'b1;
      checkOutput("bp_count", nrx, 6);
      for (int i = 0; i < 6; i++) checkOutput("bp_data", rx[i], 8'hA0 + 8'(i));

      $display("[TB] reset mid-frame");
      sent     = 0;
      accepted = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (accepted) sent++;
         applyStimulus(1, 1'b1, 8'h30 + 8'(sent), 1'b0);
         #1;
         if (c == 1) checkOutput("rmf_gi", grant_index, 1);
         accepted = s_axis_tready[1] && s_axis_tvalid[1];
         @(negedge clk);
      end
      reset = 1'b1;
      applyStimulus(0, 1'b1, 8'h77, 1'b0);
      @(negedge clk);
      checkOutput("rmf_gv",     grant_valid, 0);
      checkOutput("rmf_gi0",    grant_index, 0);
      checkOutput("rmf_tc",     truncated_count, 0);
      checkOutput("rmf_sready", s_axis_tready, 0);
      checkOutput("rmf_mvalid", m_axis_tvalid, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rmf_regrant_gv",  grant_valid, 1);
      checkOutput("rmf_regrant_gi",  grant_index, 0);
      checkOutput("rmf_regrant_tid", m_axis_tid, 0);
      idleAll();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
